instr_fetch_unit: RTL and testbench

//  Front end of the multi-cycle core, directly upstream of the control FSM. Holds the PC,

---
 rtl/instr_fetch_unit_pkg.sv | 24 ++
 rtl/instr_fetch_unit_branch_resolve.sv | 32 +++
 rtl/instr_fetch_unit.sv | 97 +++++++++
 tb/tb_instr_fetch_unit.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit.
// Covers branch encodings, opcode constants, fetch-state encodings and the reset PC default.
package instr_fetch_unit_pkg;

   localparam logic [31:0] DEFAULT_RESET_PC = '0;
   localparam int unsigned OP_W             = 4;

   typedef enum logic [2:0] {
      BR_NONE = 3'b000,
      BR_BR   = 3'b001,
      BR_BMI  = 3'b010,
      BR_BPL  = 3'b011,
      BR_BZ   = 3'b100
   } branch_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_REQ  = 2'b01,
      S_HOLD = 2'b10
   } fetch_state_e;

   localparam logic [OP_W-1:0] OP_NOP = 4'h0;

endpackage

// File: rtl/instr_fetch_unit_branch_resolve.sv
// Combinational branch resolution.
// Takes BRANCH code and ALU flags; produces the taken decision and the next PC.
module branch_resolve
   import instr_fetch_unit_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned PC_INC = 4
) (
   input  logic [2:0]        branch,
   input  logic              flag_n,
   input  logic              flag_z,
   input  logic [ADDR_W-1:0] pc,
   input  logic [ADDR_W-1:0] target,
   output logic              taken,
   output logic [ADDR_W-1:0] next_pc
);

   always_comb begin
      taken = 1'b0;
      case (branch)
         BR_BR:   taken = 1'b1;
         BR_BMI:  taken = flag_n;
         BR_BPL:  taken = ~flag_n & ~flag_z;
         BR_BZ:   taken = flag_z;
         default: taken = 1'b0;
      endcase
   end

   // Sequential path wraps modulo 2^ADDR_W.
   assign next_pc = taken ? target : pc + ADDR_W'(PC_INC);

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch front end: PC register, instruction register and the req/ack fetch FSM.
// Next-PC selection is delegated to branch_resolve.
module instr_fetch_unit
   import instr_fetch_unit_pkg::*;
#(
   parameter int unsigned       ADDR_W   = 32,
   parameter int unsigned       INSTR_W  = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC),
   parameter int unsigned       PC_INC   = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               loadPC,
   input  logic [2:0]         BRANCH,
   input  logic               flag_n,
   input  logic               flag_z,
   input  logic [ADDR_W-1:0]  branch_target,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               imem_ack,
   output logic [ADDR_W-1:0]  pc,
   output logic [INSTR_W-1:0] instr,
   output logic [OP_W-1:0]    op_code,
   output logic               instr_valid,
   output logic               br_taken,
   output logic               fetch_err
);

   fetch_state_e      state, state_nxt;
   logic              taken;
   logic [ADDR_W-1:0] next_pc;
   logic              commit;
   logic              fill;

   branch_resolve #(
      .ADDR_W (ADDR_W),
      .PC_INC (PC_INC)
   ) u_branch_resolve (
      .branch  (BRANCH),
      .flag_n  (flag_n),
      .flag_z  (flag_z),
      .pc      (pc),
      .target  (branch_target),
      .taken   (taken),
      .next_pc (next_pc)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  state_nxt = S_REQ;
         S_REQ:   if (imem_ack) state_nxt = S_HOLD;
         S_HOLD:  if (loadPC)   state_nxt = S_REQ;
         default: state_nxt = S_IDLE;
      endcase
   end

   // imem_req decodes straight from the state register so reset drops it immediately.
   always_comb begin
      imem_req = (state == S_REQ);
      fill     = (state == S_REQ)  && imem_ack;
      commit   = (state == S_HOLD) && loadPC;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc          <= RESET_PC;
         instr       <= '0;
         instr_valid <= 1'b0;
         br_taken    <= 1'b0;
         fetch_err   <= 1'b0;
      end else begin
         br_taken <= 1'b0;
         if (fill) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
         end
         if (commit) begin
            pc          <= next_pc;
            instr_valid <= 1'b0;
            br_taken    <= taken;
         end
         if (loadPC && !instr_valid)
            fetch_err <= 1'b1;
      end
   end

   assign imem_addr = pc;
   assign op_code   = instr[INSTR_W-1 -: OP_W];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a memory model serves fetches and a
// monitor scoreboards every newly presented instruction against queued expectations.
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        loadPC;
   logic [2:0]  BRANCH;
   logic        flag_n, flag_z;
   logic [31:0] branch_target;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_ack;
   logic [31:0] pc;
   logic [31:0] instr;
   logic [3:0]  op_code;
   logic        instr_valid;
   logic        br_taken;
   logic        fetch_err;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } fetch_t;
   fetch_t exp_q[$];

   logic [31:0] last_data;

   always #5 clk = ~clk;

   instr_fetch_unit #(
      .ADDR_W   (32),
      .INSTR_W  (32),
      .RESET_PC (32'h0),
      .PC_INC   (4)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .loadPC        (loadPC),
      .BRANCH        (BRANCH),
      .flag_n        (flag_n),
      .flag_z        (flag_z),
      .branch_target (branch_target),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_rdata    (imem_rdata),
      .imem_ack      (imem_ack),
      .pc            (pc),
      .instr         (instr),
      .op_code       (op_code),
      .instr_valid   (instr_valid),
      .br_taken      (br_taken),
      .fetch_err     (fetch_err)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Monitor: every rising instr_valid must match the oldest queued fetch.
   logic prev_valid = 1'b0;
   always @(negedge clk) begin
      if (instr_valid && !prev_valid) begin
         if (exp_q.size() == 0) begin
            check("unexpected_fetch", 64'(instr), 64'hFFFF_FFFF_FFFF_FFFF);
         end else begin
            fetch_t e;
            e = exp_q.pop_front();
            check("sb_pc", 64'(pc), 64'(e.addr));
            check("sb_instr", 64'(instr), 64'(e.data));
            check("sb_opcode", 64'(op_code), 64'(e.data[31:28]));
         end
      end
      prev_valid <= instr_valid;
   end

   // Memory model: wait (bounded) for a request, optionally stall, then ack once.
   task automatic serve(input logic [31:0] addr, input logic [31:0] data,
                        input int delay, input bit pulse_load, output int waited);
      waited = 0;
      while (!imem_req && waited < 20) begin
         @(posedge clk); #1;
         waited++;
      end
      check("req_seen", 64'(imem_req), 64'd1);
      check("req_addr", 64'(imem_addr), 64'(addr));
      for (int i = 0; i < delay; i++) begin
         if (pulse_load && i == 1) begin
            loadPC = 1'b1; BRANCH = 3'b001; branch_target = 32'hDEAD_BEE0;
         end
         @(posedge clk); #1;
         loadPC = 1'b0;
         check("stall_req", 64'(imem_req), 64'd1);
         check("stall_addr", 64'(imem_addr), 64'(addr));
         check("stall_pc", 64'(pc), 64'(addr));
      end
      exp_q.push_back('{addr: addr, data: data});
      imem_ack = 1'b1; imem_rdata = data;
      @(posedge clk); #1;
      imem_ack = 1'b0; imem_rdata = 32'h0;
      last_data = data;
      check("valid_after_ack", 64'(instr_valid), 64'd1);
      check("req_after_ack", 64'(imem_req), 64'd0);
   endtask

   task automatic do_load(input logic [2:0] br, input logic n, input logic z,
                          input logic [31:0] tgt, input logic [31:0] exp_pc, input logic exp_taken);
      loadPC = 1'b1; BRANCH = br; flag_n = n; flag_z = z; branch_target = tgt;
      @(posedge clk); #1;
      loadPC = 1'b0; BRANCH = 3'b000; flag_n = 1'b0; flag_z = 1'b0; branch_target = 32'h0;
      check("load_pc", 64'(pc), 64'(exp_pc));
      check("load_taken", 64'(br_taken), 64'(exp_taken));
      check("load_valid_drop", 64'(instr_valid), 64'd0);
      @(posedge clk); #1;
      check("taken_cleared", 64'(br_taken), 64'd0);
   endtask

   task automatic load_and_fetch(input logic [2:0] br, input logic n, input logic z,
                                 input logic [31:0] tgt, input logic [31:0] exp_pc,
                                 input logic exp_taken, input logic [31:0] data);
      int w;
      do_load(br, n, z, tgt, exp_pc, exp_taken);
      serve(exp_pc, data, 0, 1'b0, w);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      reset = 1'b1; loadPC = 1'b0; BRANCH = 3'b000; flag_n = 1'b0; flag_z = 1'b0;
      branch_target = 32'h0; imem_rdata = 32'h0; imem_ack = 1'b0; last_data = 32'h0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_pc", 64'(pc), 64'h0);
      check("rst_instr", 64'(instr), 64'h0);
      check("rst_valid", 64'(instr_valid), 64'd0);
      check("rst_req", 64'(imem_req), 64'd0);
      check("rst_taken", 64'(br_taken), 64'd0);
      check("rst_err", 64'(fetch_err), 64'd0);
      reset = 1'b0;

      // 1: first fetch, ack in the first S_REQ cycle
      serve(32'h0, 32'h1000_0000, 0, 1'b0, w);
      check("idle_one_cycle", 64'(w), 64'd1);
      check("first_opcode", 64'(op_code), 64'h1);

      // 2: sequential from 0x10
      load_and_fetch(3'b001, 1'b0, 1'b0, 32'h10, 32'h10, 1'b1, 32'h2000_0010);
      load_and_fetch(3'b000, 1'b1, 1'b1, 32'h80, 32'h14, 1'b0, 32'h3000_0014);

      // 3: BMI from 0x20
      load_and_fetch(3'b001, 1'b0, 1'b0, 32'h20, 32'h20, 1'b1, 32'h4000_0020);
      load_and_fetch(3'b010, 1'b1, 1'b0, 32'h80, 32'h80, 1'b1, 32'h5000_0080);
      load_and_fetch(3'b001, 1'b0, 1'b0, 32'h20, 32'h20, 1'b1, 32'h6000_0020);
      load_and_fetch(3'b010, 1'b0, 1'b0, 32'h80, 32'h24, 1'b0, 32'h7000_0024);

      // 4: BPL / BZ / reserved code
      load_and_fetch(3'b011, 1'b0, 1'b1, 32'h80,  32'h28,  1'b0, 32'h8000_0028);
      load_and_fetch(3'b011, 1'b0, 1'b0, 32'h100, 32'h100, 1'b1, 32'h9000_0100);
      load_and_fetch(3'b011, 1'b1, 1'b0, 32'h300, 32'h104, 1'b0, 32'h9100_0104);
      load_and_fetch(3'b100, 1'b0, 1'b1, 32'h200, 32'h200, 1'b1, 32'hA000_0200);
      load_and_fetch(3'b100, 1'b1, 1'b0, 32'h300, 32'h204, 1'b0, 32'hA100_0204);
      load_and_fetch(3'b111, 1'b1, 1'b1, 32'h300, 32'h208, 1'b0, 32'hB000_0208);

      // Stray ack in S_HOLD must not touch the IR
      imem_ack = 1'b1; imem_rdata = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      imem_ack = 1'b0; imem_rdata = 32'h0;
      check("stray_ack_instr", 64'(instr), 64'(last_data));
      check("stray_ack_err", 64'(fetch_err), 64'd0);

      // 5: late ack with an illegal loadPC during the wait
      do_load(3'b000, 1'b0, 1'b0, 32'h0, 32'h20C, 1'b0);
      serve(32'h20C, 32'hC000_020C, 5, 1'b1, w);
      check("err_set", 64'(fetch_err), 64'd1);
      check("pc_after_stall", 64'(pc), 64'h20C);
      load_and_fetch(3'b000, 1'b0, 1'b0, 32'h0, 32'h210, 1'b0, 32'hD000_0210);
      check("err_sticky", 64'(fetch_err), 64'd1);

      // 6: wrap at the top, then reset mid-request with a simultaneous ack
      load_and_fetch(3'b001, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b1, 32'hE000_FFFC);
      do_load(3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      check("wrap_req", 64'(imem_req), 64'd1);
      reset = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hF000_0000;
      #1;
      check("async_req_drop", 64'(imem_req), 64'd0);
      check("async_valid", 64'(instr_valid), 64'd0);
      @(posedge clk); #1;
      imem_ack = 1'b0; imem_rdata = 32'h0;
      check("rst2_valid", 64'(instr_valid), 64'd0);
      check("rst2_instr", 64'(instr), 64'h0);
      check("rst2_pc", 64'(pc), 64'h0);
      check("rst2_err", 64'(fetch_err), 64'd0);
      reset = 1'b0;
      serve(32'h0, 32'h1234_5678, 0, 1'b0, w);
      check("post_rst_idle", 64'(w), 64'd1);

      @(posedge clk); #1;
      check("queue_drained", 64'(exp_q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
